// File: rtl/dt_gen.sv
// Dead-time generator: turns one PWM command into complementary high/low gate drives
// with a programmable all-off gap inserted at every commutation.
module dt_gen #(
    parameter int DT_W   = 5,
    parameter int MIN_DT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_pwm,
    input  logic [DT_W-1:0] i_dt,
    output logic            o_hs,
    output logic            o_ls,
    output logic            o_dt_active,
    output logic            o_abort
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DT_H = 3'd1,
        HS   = 3'd2,
        DT_L = 3'd3,
        LS   = 3'd4
    } state_t;

    localparam logic [DT_W-1:0] MIN_DT_V = DT_W'(MIN_DT);

    state_t          state_reg, state_next;
    logic [DT_W-1:0] cnt_reg, cnt_next;
    logic            abort_reg, abort_next;
    logic [DT_W-1:0] dt_eff;

    assign dt_eff = (i_dt < MIN_DT_V) ? MIN_DT_V : i_dt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            abort_reg <= abort_next;
        end
    end

    // Every entry into a dead-time state reloads the full dt_eff, so the counter
    // only ever decrements from a value >= 1 and leaves at 1; it cannot wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        abort_next = 1'b0;
        if (!i_en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = i_pwm ? DT_H : DT_L;
                    cnt_next   = dt_eff;
                end
                LS: begin
                    if (i_pwm) begin
                        state_next = DT_H;
                        cnt_next   = dt_eff;
                    end
                end
                HS: begin
                    if (!i_pwm) begin
                        state_next = DT_L;
                        cnt_next   = dt_eff;
                    end
                end
                DT_H: begin
                    if (!i_pwm) begin
                        state_next = DT_L;
                        cnt_next   = dt_eff;
                        abort_next = 1'b1;
                    end else if (cnt_reg == DT_W'(1)) begin
                        state_next = HS;
                    end else begin
                        cnt_next = cnt_reg - DT_W'(1);
                    end
                end
                DT_L: begin
                    if (i_pwm) begin
                        state_next = DT_H;
                        cnt_next   = dt_eff;
                        abort_next = 1'b1;
                    end else if (cnt_reg == DT_W'(1)) begin
                        state_next = LS;
                    end else begin
                        cnt_next = cnt_reg - DT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Gate drives decode distinct states, so they can never be high together.
    assign o_hs        = (state_reg == HS);
    assign o_ls        = (state_reg == LS);
    assign o_dt_active = (state_reg == DT_H) || (state_reg == DT_L);
    assign o_abort     = abort_reg;

endmodule

// File: doc/dt_gen.md
# dt_gen

Dead-time generator for the half-bridge power stage. Converts one synchronous PWM command into complementary high-side/low-side gate drives. Both drives are held off for a programmable number of clock cycles at every commutation. The dead-time value comes from the dead-time select mux (codes 0-9 map to 2-20 cycles); this block sits between the PWM core and the gate-driver pins.

## Interface
- DT_W, 5, width of dead-time input in clock cycles
- MIN_DT, 1, minimum enforced dead-time; any i_dt below MIN_DT is treated as MIN_DT
- i_clk  input  1  system clock, all logic on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_en  input  1  bridge enable; low forces both gates off
- i_pwm  input  1  PWM command (1 = high side requested, 0 = low side requested), synchronous to i_clk
- i_dt  input  DT_W  dead-time in cycles, sampled on entry to each dead-time interval
- o_hs  output  1  high-side gate drive
- o_ls  output  1  low-side gate drive
- o_dt_active  output  1  high while in a dead-time interval
- o_abort  output  1  one-cycle pulse when a dead-time interval is aborted by a PWM reversal

## Operation
- States: IDLE, DT_H (dead-time before high side), HS, DT_L (dead-time before low side), LS.
- Outputs are Moore decodes of the state register:
  - o_hs = (state==HS), o_ls = (state==LS)
  - o_dt_active = DT_H or DT_L
  - o_abort is a registered pulse
- o_hs and o_ls are never both 1, in any cycle, including during reset and on enable changes.
- Effective dead-time dt_eff = max(i_dt, MIN_DT). A DT_W-bit down-counter is loaded with dt_eff on every entry to DT_H or DT_L.
- Transitions, evaluated each edge, with i_en=0 taking priority over everything:
  - Any state, i_en=0 -> IDLE.
  - IDLE, i_en=1 -> DT_H if i_pwm=1, else DT_L.
  - LS, i_pwm=1 -> DT_H.
  - HS, i_pwm=0 -> DT_L.
  - DT_H: if i_pwm=0 -> DT_L, counter reloaded, o_abort pulses. Else if cnt==1 -> HS. Else cnt decrements.
  - DT_L: mirror of DT_H (i_pwm=1 -> DT_H with reload and abort; cnt==1 -> LS).
- Abort reloads the full dt_eff. Both gates stay off continuously across the reversal.
- Changes to i_dt during an interval do not affect that interval.
- Turn-off on i_en=0 is immediate; no dead-time is inserted because both gates go low together.
- Reset: state IDLE, counter 0, and o_hs, o_ls, o_dt_active, o_abort all 0. Reset asserted mid-interval or mid-pulse drops all outputs asynchronously.

## Timing
- PWM edge sampled at edge E (state LS or HS): the active gate falls at E, visible in the following cycle.
- Both gates are off for exactly dt_eff cycles; the opposite gate rises at edge E+dt_eff.
- Enable from IDLE: the first gate rises dt_eff cycles after the first edge that sees i_en=1.
- A PWM pulse shorter than dt_eff cycles never reaches its gate. It produces one o_abort pulse and a restarted opposite interval.
- i_en falling at edge E: both gates are 0 from E.
- o_abort is high for exactly one cycle per abort. Back-to-back aborts give consecutive pulses.
- Counter never wraps: a reload occurs before any decrement below 1.

## Test plan
- Reset with i_en=1, i_pwm=1, i_dt=4: all outputs 0 during reset. After release, o_hs=0 for 4 cycles (o_dt_active=1), then o_hs=1.
- Square wave i_pwm period 40 cycles, i_dt=6: every commutation shows exactly 6 cycles with o_hs=o_ls=0, and o_hs&o_ls never 1 across 1000 cycles.
- i_dt=0: gap is 1 cycle (MIN_DT). i_dt=31: gap is 31 cycles, with no wrap.
- i_pwm high pulse of 3 cycles with i_dt=8 while in LS: o_hs stays 0, o_abort pulses once, o_ls returns 8 cycles after the abort.
- i_en dropped while in HS and again mid-DT_L: both gates 0 the next cycle and state IDLE. Re-enable gives a full dt_eff interval before any gate rises.
- i_dt changed from 4 to 12 mid-interval: the current gap stays 4, and the next commutation gap is 12. Asynchronous i_rst pulse mid-HS drops o_hs without waiting for a clock.
